se_arbiter: RTL and testbench
=============================

# se_arbiter

Round-robin access arbiter placed in front of the secure-element core multiplexer. It shares the single control/address/data port of the crypto cores among `NUM_REQ` requesters (e.g. host bridge, boot ROM sequencer, key manager). It grants exclusive ownership, forwards only the owner's bus, and returns the core's result only to that owner. Between owners it forces an all-zero module address for a fixed flush window, so every core sits in reset before the next owner runs (deselected cores are held in reset).

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `FLUSH_CYC`, 4: cycles with module address 0 between owners (>=1).
- `WDT_W`, 24: watchdog counter width.
- `WDT_CYC`, 24'hFF_FFFF: maximum ownership length in cycles.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, synchronous, active-low.
- `i_req`  in  NUM_REQ  request/hold; a requester keeps it high for the whole ownership.
- `i_control`  in  NUM_REQ*64  per-requester control word; [63:32] is the module address, [31:0] is the module control. Slot k is bits [64k+63:64k].
- `i_add`  in  NUM_REQ*64  per-requester address.
- `i_data_in`  in  NUM_REQ*64  per-requester write data.
- `o_gnt`  out  NUM_REQ  one-hot grant, registered.
- `o_se_control`  out  64  control word to the secure element.
- `o_se_add`  out  64  address to the secure element.
- `o_se_data_in`  out  64  data to the secure element.
- `i_se_data_out`  in  64  core read data.
- `i_se_end_op`  in  1  core end-of-operation.
- `o_data_out`  out  64  read data returned to the owner.
- `o_end_op`  out  NUM_REQ  end-of-operation, routed to the owner only.
- `o_busy`  out  1  high in GRANT or FLUSH.
- `o_timeout`  out  1  one-cycle pulse when the watchdog revokes a grant.

## Operation
- State IDLE:
  - o_se_* = 0.
  - Round-robin search over eligible requesters, starting at `ptr`. Eligible means `i_req[k]` is high and the requester is not masked.
  - Winner k: latch `owner`=k, set `ptr`=(k+1) mod NUM_REQ, go to GRANT.
- State GRANT:
  - `o_gnt`=1<<owner.
  - o_se_control, o_se_add and o_se_data_in equal the owner's slot (combinational mux on registered `owner`).
  - o_data_out = i_se_data_out.
  - o_end_op[owner] = i_se_end_op; all other bits are 0.
- Release: `i_req[owner]`=0 -> FLUSH.
- State FLUSH:
  - o_se_* = 0 and o_gnt = 0.
  - Counter runs FLUSH_CYC cycles, then IDLE.
  - Requests are ignored during FLUSH.
- Outside GRANT: o_data_out = 0 and o_end_op = 0. No data leaks to non-owners.
- Mask: a requester whose grant was revoked by the watchdog is masked until it drives `i_req` low for at least one cycle.
- Simultaneous requests: resolved purely by `ptr`. No requester waits more than NUM_REQ-1 grants.
- Reset (any state, including mid-operation):
  - Next cycle: IDLE, ptr=0, owner=0, masks cleared, flush/WDT counters cleared.
  - All outputs 0. With o_se_control=0, every core is held in reset.

## Timing
- Request high at edge t in IDLE -> o_gnt high after edge t+1. First forwarded word reaches the core in cycle t+1.
- Deassert at edge t in GRANT -> o_gnt low and o_se_* = 0 after edge t+1. FLUSH covers cycles t+1..t+FLUSH_CYC, IDLE at t+FLUSH_CYC+1.
- Minimum owner-to-owner gap is FLUSH_CYC+1 cycles.
- i_se_end_op and i_se_data_out pass combinationally to the owner; the arbiter adds no latency.
- Watchdog counter clears on entry to GRANT and increments each GRANT cycle.

## Configuration
- `SE_ARB_WDT_EN` defined:
  - When the counter reaches WDT_CYC-1 in GRANT, go to FLUSH and pulse o_timeout.
  - The owner is masked.
  - Ownership lasts at most WDT_CYC cycles.
- Not defined:
  - No watchdog counter and no masking logic.
  - o_timeout is tied 0.
  - Ownership is unbounded.

## Test plan
- Reset: hold i_rst=0 with all i_req=1 -> all outputs 0. First grant after release is o_gnt=4'b0001.
- Single owner: req[2] with control=64'h0000_0030_0000_0001 -> o_se_control equals it one cycle later. i_se_end_op=1 -> o_end_op=4'b0100 and o_data_out = i_se_data_out.
- Round robin: all four requesting, each releasing after 10 cycles -> grant order 0,1,2,3,0. Each gap is 5 cycles of o_se_control=0.
- Release during i_se_end_op=1 -> next cycle o_end_op=0 and o_data_out=0, then FLUSH for 4 cycles.
- Watchdog (macro on, WDT_CYC=100): req[1] held for 150 cycles -> o_timeout pulses once after 100 grant cycles. req[1] is not regranted while held; it is regranted after a 1-cycle low and the 4-cycle flush.
- Reset asserted mid-GRANT -> next cycle o_gnt=0, o_se_control=0, ptr=0.

Source files
------------

// File: rtl/se_arbiter.sv
// se_arbiter
// Round-robin owner arbiter in front of the secure-element core multiplexer.
// One requester at a time owns the shared control/address/data port; only the
// owner's bus is forwarded and only the owner sees the core's result. Between
// owners the module address is forced to zero for FLUSH_CYC cycles so every
// core passes through reset before the next owner runs.
//
// Optional feature: define SE_ARB_WDT_EN to enable the ownership watchdog
// (grant revoked after WDT_CYC cycles, revoked requester masked until it
// drops i_req for a cycle). Without it o_timeout is tied low and ownership
// is unbounded.
//
// Ports
//   i_clk          clock
//   i_rst          synchronous reset, active low
//   i_req          per-requester request/hold
//   i_control      per-requester control word, slot k = [64k+63:64k]
//   i_add          per-requester address
//   i_data_in      per-requester write data
//   o_gnt          registered one-hot grant
//   o_se_control   control word to the secure element
//   o_se_add       address to the secure element
//   o_se_data_in   write data to the secure element
//   i_se_data_out  core read data
//   i_se_end_op    core end-of-operation
//   o_data_out     read data returned to the owner
//   o_end_op       end-of-operation, owner bit only
//   o_busy         high in GRANT or FLUSH
//   o_timeout      one-cycle pulse when the watchdog revokes a grant
//
// State table
//   state    | meaning
//   ST_IDLE  | no owner, bus zeroed, round-robin search from ptr
//   ST_GRANT | owner's bus forwarded, core result routed to owner
//   ST_FLUSH | module address held at zero, requests ignored

module se_arbiter #(
  parameter int              NUM_REQ   = 4,
  parameter int              FLUSH_CYC = 4,
  parameter int              WDT_W     = 24,
  parameter logic [WDT_W-1:0] WDT_CYC  = 24'hFF_FFFF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ*64-1:0] i_control,
  input  logic [NUM_REQ*64-1:0] i_add,
  input  logic [NUM_REQ*64-1:0] i_data_in,
  output logic [NUM_REQ-1:0]   o_gnt,
  output logic [63:0]          o_se_control,
  output logic [63:0]          o_se_add,
  output logic [63:0]          o_se_data_in,
  input  logic [63:0]          i_se_data_out,
  input  logic                 i_se_end_op,
  output logic [63:0]          o_data_out,
  output logic [NUM_REQ-1:0]   o_end_op,
  output logic                 o_busy,
  output logic                 o_timeout
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // flush counter only ever holds FLUSH_CYC-1 down to 0
  localparam int FL_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   win;
  logic [PTR_W:0]     scan;
  logic               found;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [FL_W-1:0]    flush_cnt_q;
  logic               wdt_hit;

`ifdef SE_ARB_WDT_EN
  logic [WDT_W-1:0]   wdt_cnt_q;
  logic [NUM_REQ-1:0] mask_q;
  logic               timeout_q;

  assign eligible  = i_req & ~mask_q;
  // counter is zero in the first GRANT cycle, so this fires in cycle WDT_CYC
  assign wdt_hit   = (state_q == ST_GRANT) && (wdt_cnt_q == WDT_CYC - 1'b1);
  assign o_timeout = timeout_q;
`else
  assign eligible  = i_req;
  assign wdt_hit   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // Round-robin search: first eligible requester at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    scan  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (scan >= (PTR_W+1)'(NUM_REQ)) scan = scan - (PTR_W+1)'(NUM_REQ);
      if (!found && eligible[scan[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = scan[PTR_W-1:0];
      end
    end
  end

  // State register and datapath registers
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      gnt_q       <= '0;
      flush_cnt_q <= '0;
`ifdef SE_ARB_WDT_EN
      wdt_cnt_q   <= '0;
      mask_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;

      if (state_q == ST_GRANT && state_d == ST_FLUSH)
        flush_cnt_q <= FL_W'(FLUSH_CYC - 1);
      else if (state_q == ST_FLUSH && flush_cnt_q != '0)
        flush_cnt_q <= flush_cnt_q - 1'b1;

`ifdef SE_ARB_WDT_EN
      // held at zero outside GRANT, so it is clear on every GRANT entry
      if (state_q != ST_GRANT)
        wdt_cnt_q <= '0;
      else
        wdt_cnt_q <= wdt_cnt_q + 1'b1;

      // a mask bit survives only while its request stays high
      mask_q    <= (mask_q & i_req) | (wdt_hit ? (ONE << owner_q) : '0);
      timeout_q <= wdt_hit;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_GRANT;
          owner_d = win;
          ptr_d   = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end
      end
      ST_GRANT: begin
        if (!i_req[owner_q] || wdt_hit) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    gnt_d = (state_d == ST_GRANT) ? (ONE << owner_d) : '0;
  end

  // Output logic: everything is zero unless a grant is active
  always_comb begin
    o_se_control = '0;
    o_se_add     = '0;
    o_se_data_in = '0;
    o_data_out   = '0;
    o_end_op     = '0;
    if (state_q == ST_GRANT) begin
      o_se_control = i_control[int'(owner_q)*64 +: 64];
      o_se_add     = i_add[int'(owner_q)*64 +: 64];
      o_se_data_in = i_data_in[int'(owner_q)*64 +: 64];
      o_data_out   = i_se_data_out;
      o_end_op     = i_se_end_op ? (ONE << owner_q) : '0;
    end
  end

  assign o_gnt  = gnt_q;
  assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_se_arbiter.sv
module tb_se_arbiter;

  localparam int N = 4;
  localparam logic [63:0] SE_DATA = 64'h5EC0_DA7A_0000_1234;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b0;
  logic [N-1:0]    i_req = '0;
  logic [N*64-1:0] i_control;
  logic [N*64-1:0] i_add;
  logic [N*64-1:0] i_data_in;
  logic [N-1:0]    o_gnt;
  logic [63:0]     o_se_control, o_se_add, o_se_data_in;
  logic [63:0]     i_se_data_out = SE_DATA;
  logic            i_se_end_op = 1'b0;
  logic [63:0]     o_data_out;
  logic [N-1:0]    o_end_op;
  logic            o_busy, o_timeout;

  logic [63:0] ctl_tab [N];
  logic [63:0] add_tab [N];
  logic [63:0] din_tab [N];

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  se_arbiter #(
    .NUM_REQ(N), .FLUSH_CYC(4), .WDT_W(24), .WDT_CYC(24'd100)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req),
    .i_control(i_control), .i_add(i_add), .i_data_in(i_data_in),
    .o_gnt(o_gnt), .o_se_control(o_se_control), .o_se_add(o_se_add),
    .o_se_data_in(o_se_data_in), .i_se_data_out(i_se_data_out),
    .i_se_end_op(i_se_end_op), .o_data_out(o_data_out),
    .o_end_op(o_end_op), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // slot < 0 means no owner: bus, read data and end_op all zero
  task automatic check_outs(input string tag, input logic [N-1:0] gnt, input int slot,
                            input logic [N-1:0] endo, input logic busy);
    chk({tag, ".gnt"},  64'(o_gnt), 64'(gnt));
    chk({tag, ".ctl"},  o_se_control, (slot < 0) ? 64'h0 : ctl_tab[slot]);
    chk({tag, ".add"},  o_se_add,     (slot < 0) ? 64'h0 : add_tab[slot]);
    chk({tag, ".din"},  o_se_data_in, (slot < 0) ? 64'h0 : din_tab[slot]);
    chk({tag, ".dout"}, o_data_out,   (slot < 0) ? 64'h0 : SE_DATA);
    chk({tag, ".end"},  64'(o_end_op), 64'(endo));
    chk({tag, ".busy"}, 64'(o_busy),  64'(busy));
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         end_op;
    logic [N-1:0] gnt;
    int           slot;
    logic [N-1:0] endo;
    logic         busy;
  } vec_t;

  vec_t vt [24];

  initial begin
    int order [5];
    int gap, n, gcyc, tos, tcyc;
    logic [N-1:0] cur;

    ctl_tab[0] = 64'h0000_0010_0000_00A0;
    ctl_tab[1] = 64'h0000_0020_0000_00B1;
    ctl_tab[2] = 64'h0000_0030_0000_0001;
    ctl_tab[3] = 64'h0000_0040_0000_00D3;
    for (int k = 0; k < N; k++) begin
      add_tab[k] = 64'hADD0_0000_0000_0000 | 64'(k + 1);
      din_tab[k] = 64'hDA7A_0000_0000_0000 | 64'((k + 1) << 8);
      i_control[k*64 +: 64] = ctl_tab[k];
      i_add[k*64 +: 64]     = add_tab[k];
      i_data_in[k*64 +: 64] = din_tab[k];
    end

    // ptr = 1 entering the table (requester 0 already granted once)
    vt[0]  = '{4'b0100, 1'b0, 4'b0100,  2, 4'b0000, 1'b1};
    vt[1]  = '{4'b0100, 1'b1, 4'b0100,  2, 4'b0100, 1'b1};
    vt[2]  = '{4'b0100, 1'b0, 4'b0100,  2, 4'b0000, 1'b1};
    vt[3]  = '{4'b0101, 1'b0, 4'b0100,  2, 4'b0000, 1'b1};
    vt[4]  = '{4'b0001, 1'b1, 4'b0000, -1, 4'b0000, 1'b1};
    vt[5]  = '{4'b0001, 1'b0, 4'b0000, -1, 4'b0000, 1'b1};
    vt[6]  = '{4'b0001, 1'b0, 4'b0000, -1, 4'b0000, 1'b1};
    vt[7]  = '{4'b0001, 1'b0, 4'b0000, -1, 4'b0000, 1'b1};
    vt[8]  = '{4'b0001, 1'b0, 4'b0000, -1, 4'b0000, 1'b0};
    vt[9]  = '{4'b0001, 1'b0, 4'b0001,  0, 4'b0000, 1'b1};
    vt[10] = '{4'b0000, 1'b1, 4'b0000, -1, 4'b0000, 1'b1};
    vt[11] = '{4'b0000, 1'b0, 4'b0000, -1, 4'b0000, 1'b1};
    vt[12] = '{4'b0000, 1'b0, 4'b0000, -1, 4'b0000, 1'b1};
    vt[13] = '{4'b0000, 1'b0, 4'b0000, -1, 4'b0000, 1'b1};
    vt[14] = '{4'b0000, 1'b0, 4'b0000, -1, 4'b0000, 1'b0};
    vt[15] = '{4'b1010, 1'b0, 4'b0010,  1, 4'b0000, 1'b1};
    vt[16] = '{4'b1010, 1'b1, 4'b0010,  1, 4'b0010, 1'b1};
    vt[17] = '{4'b1000, 1'b0, 4'b0000, -1, 4'b0000, 1'b1};
    vt[18] = '{4'b1000, 1'b0, 4'b0000, -1, 4'b0000, 1'b1};
    vt[19] = '{4'b1000, 1'b0, 4'b0000, -1, 4'b0000, 1'b1};
    vt[20] = '{4'b1000, 1'b0, 4'b0000, -1, 4'b0000, 1'b1};
    vt[21] = '{4'b1000, 1'b0, 4'b0000, -1, 4'b0000, 1'b0};
    vt[22] = '{4'b1000, 1'b0, 4'b1000,  3, 4'b0000, 1'b1};
    vt[23] = '{4'b0000, 1'b0, 4'b0000, -1, 4'b0000, 1'b1};

    // Reset held with everyone requesting
    i_rst = 1'b0; i_req = 4'b1111; i_se_end_op = 1'b1;
    repeat (3) tick();
    check_outs("rst", 4'b0000, -1, 4'b0000, 1'b0);
    chk("rst.timeout", 64'(o_timeout), 64'h0);
    i_rst = 1'b1; i_se_end_op = 1'b0;
    tick();
    check_outs("first", 4'b0001, 0, 4'b0000, 1'b1);
    i_req = 4'b0000;
    repeat (6) tick();

    // Directed vector table
    for (int v = 0; v < 24; v++) begin
      i_req = vt[v].req;
      i_se_end_op = vt[v].end_op;
      tick();
      check_outs($sformatf("vec%0d", v), vt[v].gnt, vt[v].slot, vt[v].endo, vt[v].busy);
    end
    i_req = 4'b0000; i_se_end_op = 1'b0;
    repeat (6) tick();

    // Round robin with all four requesting, 10-cycle ownerships
    order = '{0, 1, 2, 3, 0};
    i_req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      gap = 0; n = 0;
      while (o_gnt == '0 && n < 20) begin
        gap++;
        if (o_se_control != 64'h0) chk($sformatf("rr%0d.gapctl", g), o_se_control, 64'h0);
        tick();
        n++;
      end
      chk($sformatf("rr%0d.gnt", g), 64'(o_gnt), 64'(4'b0001 << order[g]));
      if (g > 0) chk($sformatf("rr%0d.gap", g), 64'(gap), 64'd5);
      chk($sformatf("rr%0d.ctl", g), o_se_control, ctl_tab[order[g]]);
      repeat (9) tick();
      chk($sformatf("rr%0d.hold", g), 64'(o_gnt), 64'(4'b0001 << order[g]));
      cur = o_gnt;
      i_req = i_req & ~cur;
      tick();
      if (g < 4) i_req = i_req | cur;
    end
    i_req = 4'b0000;
    repeat (6) tick();

    // Long hold by requester 1 (ptr = 1 here)
    i_req = 4'b0010;
    tick();
    chk("wdt.gnt", 64'(o_gnt), 64'(4'b0010));
    gcyc = 1; tos = 0; tcyc = 0;
    for (int c = 2; c <= 150; c++) begin
      tick();
      if (o_gnt == 4'b0010) gcyc++;
      if (o_timeout) begin
        tos++;
        tcyc = c;
      end
    end
`ifdef SE_ARB_WDT_EN
    chk("wdt.grant_cycles", 64'(gcyc), 64'd100);
    chk("wdt.pulses", 64'(tos), 64'd1);
    chk("wdt.pulse_cycle", 64'(tcyc), 64'd101);
    chk("wdt.masked", 64'(o_gnt), 64'h0);
    i_req = 4'b0000;
    tick();
    i_req = 4'b0010;
    tick();
    chk("wdt.regrant", 64'(o_gnt), 64'(4'b0010));
    chk("wdt.regrant_to", 64'(o_timeout), 64'h0);
`else
    chk("nowdt.grant_cycles", 64'(gcyc), 64'd150);
    chk("nowdt.pulses", 64'(tos), 64'd0);
    chk("nowdt.gnt", 64'(o_gnt), 64'(4'b0010));
`endif
    i_req = 4'b0000;
    repeat (6) tick();

    // Reset mid-GRANT (ptr = 2 here; becomes 3 after this grant)
    i_req = 4'b0100;
    tick();
    chk("rstmid.gnt", 64'(o_gnt), 64'(4'b0100));
    i_se_end_op = 1'b1;
    #1;
    chk("rstmid.end", 64'(o_end_op), 64'(4'b0100));
    i_rst = 1'b0;
    tick();
    check_outs("rstmid", 4'b0000, -1, 4'b0000, 1'b0);
    chk("rstmid.timeout", 64'(o_timeout), 64'h0);
    i_rst = 1'b1; i_se_end_op = 1'b0; i_req = 4'b1100;
    tick();
    // ptr back at 0: search 0,1,2 picks 2 ahead of 3
    chk("rstmid.ptr", 64'(o_gnt), 64'(4'b0100));
    i_req = 4'b0000;
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
